inst_mem_arbiter: RTL and testbench

//  Shares the single-port instruction SRAM between three requesters: boot loader writes,
//  CPU instruction fetch and a debug read/write port.

---
 rtl/inst_mem_arbiter_pkg.sv | 11 +
 rtl/inst_mem_arbiter_prio_sel.sv | 26 ++
 rtl/inst_mem_arbiter.sv | 104 ++++++++++
 tb/tb_inst_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_arbiter_pkg.sv
// Shared definitions for the instruction SRAM arbiter: requester identifiers.
package inst_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ID_NONE  = 2'd0,
    ID_BOOT  = 2'd1,
    ID_FETCH = 2'd2,
    ID_DBG   = 2'd3
  } req_id_e;

endpackage : inst_mem_arbiter_pkg

// File: rtl/inst_mem_arbiter_prio_sel.sv
// Combinational winner select for the instruction SRAM arbiter.
module imem_prio_sel
  import inst_mem_arbiter_pkg::*;
(
  input  logic    boot_mode,
  input  logic    boot_req,
  input  logic    fetch_req,
  input  logic    dbg_req,
  input  logic    starve,
  output req_id_e winner
);

  always_comb begin
    winner = ID_NONE;
    if (boot_mode) begin
      if (boot_req) winner = ID_BOOT;
    end else if (dbg_req && starve) begin
      winner = ID_DBG;
    end else if (fetch_req) begin
      winner = ID_FETCH;
    end else if (dbg_req) begin
      winner = ID_DBG;
    end
  end

endmodule : imem_prio_sel

// File: rtl/inst_mem_arbiter.sv
// Shares the single-port instruction SRAM between boot writes, CPU fetch and debug.
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  boot_mode,
  input  logic                  boot_req,
  input  logic [ADDR_WIDTH-1:0] boot_addr,
  input  logic [DATA_WIDTH-1:0] boot_wdata,
  output logic                  boot_gnt,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  boot_viol
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;
  logic          starve;
  req_id_e       winner;
  req_id_e       rd_owner;

  assign starve = (wait_cnt == CW'(MAX_WAIT));

  imem_prio_sel u_prio_sel (
    .boot_mode (boot_mode),
    .boot_req  (boot_req),
    .fetch_req (fetch_req),
    .dbg_req   (dbg_req),
    .starve    (starve),
    .winner    (winner)
  );

  assign boot_gnt  = (winner == ID_BOOT);
  assign fetch_gnt = (winner == ID_FETCH);
  assign dbg_gnt   = (winner == ID_DBG);

  always_comb begin
    mem_en      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (winner)
      ID_BOOT: begin
        mem_en      = 1'b1;
        mem_wr_en   = 1'b1;
        mem_addr    = boot_addr;
        mem_wr_data = boot_wdata;
      end
      ID_FETCH: begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr;
      end
      ID_DBG: begin
        mem_en      = 1'b1;
        mem_wr_en   = dbg_we;
        mem_addr    = dbg_addr;
        mem_wr_data = dbg_wdata;
      end
      default: ;
    endcase
  end

  // Owner of the read issued last cycle; decodes straight into the rvalid pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      rd_owner  <= ID_NONE;
      boot_viol <= 1'b0;
    end else begin
      if (dbg_req && !dbg_gnt) begin
        if (!starve) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      rd_owner <= (mem_en && !mem_wr_en) ? winner : ID_NONE;
      if (boot_req && !boot_mode) boot_viol <= 1'b1;
    end
  end

  assign fetch_rvalid = (rd_owner == ID_FETCH);
  assign dbg_rvalid   = (rd_owner == ID_DBG);
  assign rd_data      = mem_rd_data;

endmodule : inst_mem_arbiter

// File: tb/tb_inst_mem_arbiter.sv
// Directed bench for inst_mem_arbiter with a small behavioural SRAM behind it.
module tb_inst_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          boot_mode, boot_req, boot_gnt;
  logic [AW-1:0] boot_addr;
  logic [DW-1:0] boot_wdata;
  logic          fetch_req, fetch_gnt, fetch_rvalid;
  logic [AW-1:0] fetch_addr;
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] rd_data;
  logic          mem_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic          boot_viol;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] sram [0:255];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) sram[mem_addr[7:0]] <= mem_wr_data;
      else           mem_rd_data <= sram[mem_addr[7:0]];
    end
  end

  inst_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .boot_mode    (boot_mode),
    .boot_req     (boot_req),
    .boot_addr    (boot_addr),
    .boot_wdata   (boot_wdata),
    .boot_gnt     (boot_gnt),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_gnt      (dbg_gnt),
    .dbg_rvalid   (dbg_rvalid),
    .rd_data      (rd_data),
    .mem_en       (mem_en),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .boot_viol    (boot_viol)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    boot_req   = 1'b0;
    boot_addr  = '0;
    boot_wdata = '0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    dbg_req    = 1'b0;
    dbg_we     = 1'b0;
    dbg_addr   = '0;
    dbg_wdata  = '0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    boot_mode = 1'b1;
    idle_inputs();
    #1;
    n_vec++;
    if ({fetch_rvalid, dbg_rvalid, boot_viol} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 000", {fetch_rvalid, dbg_rvalid, boot_viol});
    end
    n_vec++;
    if ({mem_en, mem_wr_en, boot_gnt, fetch_gnt, dbg_gnt} !== 5'b0 || mem_addr !== '0 || mem_wr_data !== '0) begin
      n_err++;
      $display("FAIL reset_idle_mem: en=%b we=%b addr=%h wd=%h want all zero", mem_en, mem_wr_en, mem_addr, mem_wr_data);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_boot();
    boot_req   = 1'b1;
    boot_addr  = 20'h4;
    boot_wdata = 32'hDEADBEEF;
    fetch_req  = 1'b1;
    fetch_addr = 20'h8;
    #1;
    n_vec++;
    if ({boot_gnt, fetch_gnt, dbg_gnt} !== 3'b100) begin
      n_err++;
      $display("FAIL boot_grant: got b/f/d=%b want 100", {boot_gnt, fetch_gnt, dbg_gnt});
    end
    n_vec++;
    if (mem_en !== 1'b1 || mem_wr_en !== 1'b1 || mem_addr !== 20'h4 || mem_wr_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL boot_mem: en=%b we=%b addr=%h wd=%h want 1 1 00004 deadbeef", mem_en, mem_wr_en, mem_addr, mem_wr_data);
    end
    tick();
    boot_addr  = 20'h10;
    boot_wdata = 32'h12345678;
    tick();
    idle_inputs();
    n_vec++;
    if (fetch_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL boot_no_rvalid: got %b want 0", fetch_rvalid);
    end
  endtask

  task automatic test_fetch_read();
    boot_mode  = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 20'h10;
    #1;
    n_vec++;
    if (fetch_gnt !== 1'b1 || mem_en !== 1'b1 || mem_wr_en !== 1'b0 || mem_addr !== 20'h10) begin
      n_err++;
      $display("FAIL fetch_grant: gnt=%b en=%b we=%b addr=%h want 1 1 0 00010", fetch_gnt, mem_en, mem_wr_en, mem_addr);
    end
    tick();
    fetch_req = 1'b0;
    #1;
    n_vec++;
    if (fetch_rvalid !== 1'b1 || rd_data !== 32'h12345678) begin
      n_err++;
      $display("FAIL fetch_rdata: rvalid=%b data=%h want 1 12345678", fetch_rvalid, rd_data);
    end
    tick();
    n_vec++;
    if (fetch_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_rvalid_pulse: f=%b d=%b want 0 0", fetch_rvalid, dbg_rvalid);
    end
  endtask

  task automatic test_starvation();
    fetch_req  = 1'b1;
    fetch_addr = 20'h10;
    dbg_req    = 1'b1;
    dbg_we     = 1'b0;
    dbg_addr   = 20'h4;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      #1;
      n_vec++;
      if (cyc == 9) begin
        if ({fetch_gnt, dbg_gnt} !== 2'b01 || mem_addr !== 20'h4) begin
          n_err++;
          $display("FAIL starve_dbg_win c%0d: f/d=%b addr=%h want 01 00004", cyc, {fetch_gnt, dbg_gnt}, mem_addr);
        end
      end else if ({fetch_gnt, dbg_gnt} !== 2'b10) begin
        n_err++;
        $display("FAIL starve_fetch_win c%0d: f/d=%b want 10", cyc, {fetch_gnt, dbg_gnt});
      end
      if (cyc >= 2) begin
        n_vec++;
        if (cyc == 10) begin
          if (dbg_rvalid !== 1'b1 || fetch_rvalid !== 1'b0 || rd_data !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL starve_dbg_rdata: d=%b f=%b data=%h want 1 0 deadbeef", dbg_rvalid, fetch_rvalid, rd_data);
          end
        end else if (fetch_rvalid !== 1'b1 || dbg_rvalid !== 1'b0 || rd_data !== 32'h12345678) begin
          n_err++;
          $display("FAIL b2b_fetch_rdata c%0d: f=%b d=%b data=%h want 1 0 12345678", cyc, fetch_rvalid, dbg_rvalid, rd_data);
        end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_dbg_write();
    dbg_req   = 1'b1;
    dbg_we    = 1'b1;
    dbg_addr  = 20'h20;
    dbg_wdata = 32'h000055AA;
    #1;
    n_vec++;
    if (dbg_gnt !== 1'b1 || mem_wr_en !== 1'b1 || mem_addr !== 20'h20 || mem_wr_data !== 32'h000055AA) begin
      n_err++;
      $display("FAIL dbg_write: gnt=%b we=%b addr=%h wd=%h want 1 1 00020 000055aa", dbg_gnt, mem_wr_en, mem_addr, mem_wr_data);
    end
    tick();
    idle_inputs();
    fetch_req  = 1'b1;
    fetch_addr = 20'h20;
    #1;
    n_vec++;
    if (dbg_rvalid !== 1'b0 || fetch_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL dbg_write_no_rvalid: dbg_rvalid=%b fetch_gnt=%b want 0 1", dbg_rvalid, fetch_gnt);
    end
    tick();
    fetch_req = 1'b0;
    #1;
    n_vec++;
    if (fetch_rvalid !== 1'b1 || dbg_rvalid !== 1'b0 || rd_data !== 32'h000055AA) begin
      n_err++;
      $display("FAIL dbg_write_readback: f=%b d=%b data=%h want 1 0 000055aa", fetch_rvalid, dbg_rvalid, rd_data);
    end
    tick();
  endtask

  task automatic test_boot_viol();
    boot_req   = 1'b1;
    boot_addr  = 20'h30;
    boot_wdata = 32'hCAFEF00D;
    #1;
    n_vec++;
    if (boot_gnt !== 1'b0 || mem_en !== 1'b0 || boot_viol !== 1'b0) begin
      n_err++;
      $display("FAIL boot_viol_nogrant: gnt=%b en=%b viol=%b want 0 0 0", boot_gnt, mem_en, boot_viol);
    end
    tick();
    boot_req = 1'b0;
    #1;
    n_vec++;
    if (boot_viol !== 1'b1) begin
      n_err++;
      $display("FAIL boot_viol_set: got %b want 1", boot_viol);
    end
    repeat (3) tick();
    n_vec++;
    if (boot_viol !== 1'b1) begin
      n_err++;
      $display("FAIL boot_viol_sticky: got %b want 1", boot_viol);
    end
  endtask

  task automatic test_reset_inflight();
    fetch_req  = 1'b1;
    fetch_addr = 20'h10;
    tick();
    fetch_req = 1'b0;
    #1;
    n_vec++;
    if (fetch_rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL inflight_pre: fetch_rvalid=%b want 1", fetch_rvalid);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (fetch_rvalid !== 1'b0 || boot_viol !== 1'b0) begin
      n_err++;
      $display("FAIL inflight_reset: fetch_rvalid=%b boot_viol=%b want 0 0", fetch_rvalid, boot_viol);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (fetch_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL inflight_after c%0d: f=%b d=%b want 0 0", i, fetch_rvalid, dbg_rvalid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_fetch_read();
    test_starvation();
    test_dbg_write();
    test_boot_viol();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_inst_mem_arbiter
